spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// rtl/spi_cfg_master.sv - SPI mode-0 register master sending HDR, ADDR and DATA frames
// Define NPU_SPI_CFG_READBACK_EN to verify each write with an automatic read of the same address.
`ifndef NPU_REG_WIDTH
`define NPU_REG_WIDTH 16
`endif
`ifndef NPU_REG_ADDR_WIDTH
`define NPU_REG_ADDR_WIDTH 8
`endif
`ifndef NPU_SPI_START_HEADER
`define NPU_SPI_START_HEADER 16'hA5C3
`endif

module spi_cfg_master #(
  parameter int CLK_DIV  = 2,
  parameter int IDLE_CYC = 4
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [`NPU_REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [`NPU_REG_WIDTH-1:0]      req_wdata,
  output logic                           rsp_valid,
  output logic [`NPU_REG_WIDTH-1:0]      rsp_rdata,
  output logic                           rsp_err,
  output logic                           spi_ss,
  output logic                           spi_sclk,
  output logic                           spi_mosi,
  input  logic                           spi_miso
);
  localparam int RW      = `NPU_REG_WIDTH;
  localparam int AW      = `NPU_REG_ADDR_WIDTH;
  localparam int CNT_MAX = (2 * CLK_DIV > IDLE_CYC) ? 2 * CLK_DIV : IDLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_RISE      = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP_LAST  = CW'(IDLE_CYC - 1);
  localparam logic [RW-1:0] C_HDR       = `NPU_SPI_START_HEADER;

  typedef enum logic [2:0] {IDLE, LEAD, HDR, ADDR, DATA, TRAIL, GAP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_div;
  logic [3:0]      r_bit;
  logic [RW-1:0]   r_tx;
  logic [RW-1:0]   r_rx;
  logic [AW-1:0]   r_addr;
  logic [RW-1:0]   r_wdata;
  logic            r_write;
  logic            r_rsp_valid;
  logic [RW-1:0]   r_rsp_rdata;

  logic            w_accept;
  logic            w_in_frame;
  logic            w_half_done;
  logic            w_bit_done;
  logic            w_frame_done;
  logic            w_gap_done;
  logic            w_trail_done;
  logic            w_need_rb;
  logic            w_gap_to_lead;
  logic [7:0]      w_addr8;

  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_in_frame   = (r_state == HDR) || (r_state == ADDR) || (r_state == DATA);
  assign w_half_done  = (r_div == C_HALF_LAST);
  assign w_bit_done   = (r_div == C_BIT_LAST);
  assign w_frame_done = w_in_frame && w_bit_done && (r_bit == 4'd15);
  assign w_gap_done   = (r_div == C_GAP_LAST);
  assign w_trail_done = (r_state == TRAIL) && w_half_done;
  assign w_addr8      = 8'(r_addr);

  assign req_ready = (r_state == IDLE);
  assign spi_ss    = !((r_state == LEAD) || w_in_frame || (r_state == TRAIL));
  assign spi_sclk  = w_in_frame && (r_div >= C_RISE);
  assign spi_mosi  = w_in_frame && r_tx[RW-1];
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid)    w_state_nxt = LEAD;
      LEAD:    if (w_half_done)  w_state_nxt = HDR;
      HDR:     if (w_frame_done) w_state_nxt = ADDR;
      ADDR:    if (w_frame_done) w_state_nxt = DATA;
      DATA:    if (w_frame_done) w_state_nxt = TRAIL;
      TRAIL:   if (w_half_done)  w_state_nxt = GAP;
      GAP:     if (w_gap_done)   w_state_nxt = w_gap_to_lead ? LEAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One divider serves LEAD/TRAIL half-periods, whole bit periods and the GAP count.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;

      if ((r_state == IDLE) || (w_state_nxt != r_state) || (w_in_frame && w_bit_done)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_in_frame && w_bit_done) begin
        r_bit <= r_bit + 1'b1;
      end

      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end

      if (r_state == LEAD) begin
        r_tx <= C_HDR;
      end else if (w_in_frame && w_bit_done) begin
        if (r_bit == 4'd15) begin
          case (r_state)
            HDR:     r_tx <= RW'({(r_write ? 8'h80 : 8'h00), w_addr8});
            ADDR:    r_tx <= r_write ? r_wdata : '0;
            default: r_tx <= '0;
          endcase
        end else begin
          r_tx <= {r_tx[RW-2:0], 1'b0};
        end
      end

      // The first sclk-high cycle is the slave's data-valid point.
      if ((r_state == DATA) && (r_div == C_RISE)) begin
        r_rx <= {r_rx[RW-2:0], spi_miso};
      end

      if (w_trail_done) begin
        if (w_need_rb) begin
          r_write <= 1'b0;
        end else begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_write ? '0 : r_rx;
        end
      end
    end
  end

`ifdef NPU_SPI_CFG_READBACK_EN
  logic r_go;
  logic r_chk;
  logic r_rsp_err;

  assign w_need_rb     = r_write;
  assign w_gap_to_lead = r_go;
  assign rsp_err       = r_rsp_err;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_go      <= 1'b0;
      r_chk     <= 1'b0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_go  <= 1'b0;
      r_chk <= 1'b0;
    end else if (w_trail_done) begin
      if (r_write) begin
        r_go  <= 1'b1;
        r_chk <= 1'b1;
      end else begin
        r_go      <= 1'b0;
        r_rsp_err <= r_chk && (r_rx != r_wdata);
      end
    end
  end
`else
  assign w_need_rb     = 1'b0;
  assign w_gap_to_lead = 1'b0;
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb/tb_spi_cfg_master.sv - randomized self-checking bench for spi_cfg_master
// Two instances (CLK_DIV=2 and CLK_DIV=5) share clock and reset; a slave model observes both.
`ifndef NPU_REG_WIDTH
`define NPU_REG_WIDTH 16
`endif
`ifndef NPU_REG_ADDR_WIDTH
`define NPU_REG_ADDR_WIDTH 8
`endif
`ifndef NPU_SPI_START_HEADER
`define NPU_SPI_START_HEADER 16'hA5C3
`endif

module tb_spi_cfg_master;
  localparam logic [15:0] HDR = `NPU_SPI_START_HEADER;
  localparam int IDLE_CYC = 4;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [1:0] ss, sclk, mosi, miso;
  logic [7:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [15:0] rsp_rdata [2];
  logic [15:0] slave     [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_cfg_master #(.CLK_DIV(g == 0 ? 2 : 5), .IDLE_CYC(IDLE_CYC)) u_dut (
      .clk(clk), .reset_b(reset_b),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .spi_ss(ss[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_miso(miso[g])
    );
  end

  // Slave/bus observer state, written only by the monitor process.
  int          m_bit[2], m_frame[2], m_run[2], m_low[2], m_high[2];
  logic        m_pss[2], m_psclk[2], m_prsp[2];
  bit          m_had[2];
  logic [15:0] m_sh[2];
  logic [15:0] fr[2][128];
  int          nfr[2], lowq[2][64], nlow[2], gapq[2][64], ngap[2];
  int          phase_err[2], busy_err[2], pulse_err[2], rsp_cnt[2];
  logic [15:0] rsp_d[2];
  logic        rsp_e[2];

  function automatic int dv(input int g);
    return (g == 0) ? 2 : 5;
  endfunction

  task automatic mon_step(input int g);
    int exp_run;
    if (!reset_b) begin
      m_pss[g] = 1'b1; m_psclk[g] = 1'b0; m_prsp[g] = 1'b0; m_had[g] = 1'b0;
      m_bit[g] = 0; m_frame[g] = 0; m_run[g] = 0; m_low[g] = 0; m_high[g] = 0;
      miso[g] = 1'b0;
      return;
    end
    if (rsp_valid[g]) begin
      rsp_cnt[g]++;
      rsp_d[g] = rsp_rdata[g];
      rsp_e[g] = rsp_err[g];
      if (m_prsp[g]) pulse_err[g]++;
    end
    m_prsp[g] = rsp_valid[g];
    if (!ss[g]) begin
      if (req_ready[g]) busy_err[g]++;
      if (m_pss[g]) begin
        if (m_had[g] && ngap[g] < 64) begin gapq[g][ngap[g]] = m_high[g]; ngap[g]++; end
        m_low[g] = 0; m_run[g] = 0; m_bit[g] = 0; m_frame[g] = 0; m_sh[g] = '0;
      end
      m_low[g]++;
      if (sclk[g] != m_psclk[g]) begin
        // first rise follows LEAD plus the low half of bit 0
        exp_run = (sclk[g] && m_frame[g] == 0 && m_bit[g] == 0) ? 2 * dv(g) : dv(g);
        if (m_run[g] != exp_run) phase_err[g]++;
        m_run[g] = 0;
      end
      m_run[g]++;
      if (sclk[g] && !m_psclk[g]) begin
        miso[g] = (m_frame[g] == 2) ? slave[g][15 - m_bit[g]] : 1'($urandom);
        m_sh[g] = {m_sh[g][14:0], mosi[g]};
        m_bit[g]++;
        if (m_bit[g] == 16) begin
          if (nfr[g] < 128) begin fr[g][nfr[g]] = m_sh[g]; nfr[g]++; end
          m_bit[g] = 0;
          m_frame[g]++;
        end
      end else begin
        miso[g] = (m_frame[g] == 2) ? ~slave[g][15 - m_bit[g]] : 1'($urandom);
      end
    end else begin
      if (!m_pss[g]) begin
        if (m_run[g] != dv(g) || m_bit[g] != 0) phase_err[g]++;
        if (nlow[g] < 64) begin lowq[g][nlow[g]] = m_low[g]; nlow[g]++; end
        m_had[g] = 1'b1;
        m_high[g] = 0;
      end
      m_high[g]++;
      miso[g] = 1'($urandom);
    end
    m_pss[g] = ss[g];
    m_psclk[g] = sclk[g];
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) mon_step(g);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: frame list and response derived directly from the request.
  task automatic do_op(input int g, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                       input logic [15:0] sd, input bit hold, input string tag);
    logic [15:0] ef[6];
    logic [15:0] er;
    logic        ee;
    int ne, f0, l0, r0, n;
    slave[g] = sd;
    ne = 3;
    ef[0] = HDR;
    ef[1] = {(wr ? 8'h80 : 8'h00), a};
    ef[2] = wr ? wd : 16'h0000;
    er = wr ? 16'h0000 : sd;
    ee = 1'b0;
`ifdef NPU_SPI_CFG_READBACK_EN
    if (wr) begin
      ne = 6;
      ef[3] = HDR; ef[4] = {8'h00, a}; ef[5] = 16'h0000;
      er = sd;
      ee = (sd != wd);
    end
`endif
    f0 = nfr[g]; l0 = nlow[g]; r0 = rsp_cnt[g];
    req_write[g] = wr; req_addr[g] = a; req_wdata[g] = wd; req_valid[g] = 1'b1;
    n = 0;
    while (req_ready[g] !== 1'b1 && n < 3000) begin tick(); n++; end
    chk({tag, "/accept_timeout"}, 32'(n < 3000), 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid[g] = 1'b0;
    req_addr[g] = 8'($urandom); req_wdata[g] = 16'($urandom); req_write[g] = 1'($urandom);
    tick();
    chk({tag, "/ready_low"}, req_ready[g], 0);
    n = 0;
    while (rsp_cnt[g] == r0 && n < 8000) begin tick(); n++; end
    chk({tag, "/rsp_cnt"}, rsp_cnt[g] - r0, 1);
    chk({tag, "/nframes"}, nfr[g] - f0, ne);
    for (int i = 0; i < ne; i++) chk($sformatf("%s/frame%0d", tag, i), fr[g][f0 + i], ef[i]);
    chk({tag, "/rdata"}, rsp_d[g], er);
    chk({tag, "/err"}, rsp_e[g], ee);
    chk({tag, "/sessions"}, nlow[g] - l0, ne / 3);
    for (int i = l0; i < nlow[g]; i++) chk({tag, "/ss_low"}, lowq[g][i], 98 * dv(g));
  endtask

  initial begin
    int f0, n, r0, mn;
    bit wr;
    logic [15:0] wd, sd;
    reset_b = 1'b0;
    req_valid = '0; req_write = '0;
    for (int g = 0; g < 2; g++) begin
      req_addr[g] = '0; req_wdata[g] = '0; slave[g] = '0;
      nfr[g] = 0; nlow[g] = 0; ngap[g] = 0; rsp_cnt[g] = 0;
      phase_err[g] = 0; busy_err[g] = 0; pulse_err[g] = 0;
    end
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst/ss", ss[g], 1);
      chk("rst/sclk", sclk[g], 0);
      chk("rst/mosi", mosi[g], 0);
      chk("rst/rsp_valid", rsp_valid[g], 0);
      chk("rst/rsp_rdata", rsp_rdata[g], 0);
      chk("rst/rsp_err", rsp_err[g], 0);
    end
    @(negedge clk);
    reset_b = 1'b1;
    tick();
    chk("rst/ready0", req_ready[0], 1);
    chk("rst/ready1", req_ready[1], 1);

    do_op(0, 1'b1, 8'h03, 16'h0005, 16'h0005, 1'b0, "wr03");
    do_op(0, 1'b0, 8'h01, 16'h0000, 16'h00A7, 1'b0, "rd01");
    do_op(0, 1'b1, 8'h5A, 16'h1111, 16'h1111, 1'b1, "b2b_a");
    do_op(0, 1'b0, 8'h5B, 16'h0000, 16'hBEEF, 1'b0, "b2b_b");
    repeat (10) tick();
    chk("hold_rdata", rsp_rdata[0], 16'hBEEF);

    // Abort during bit 7 of the ADDR frame.
    f0 = nfr[0];
    req_write[0] = 1'b1; req_addr[0] = 8'h77; req_wdata[0] = 16'h7777; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 3000) begin tick(); n++; end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!(nfr[0] - f0 == 1 && m_bit[0] == 8) && n < 3000) begin tick(); n++; end
    chk("abort/reach_bit7", 32'(n < 3000), 1);
    r0 = rsp_cnt[0];
    #2 reset_b = 1'b0;
    #1;
    chk("abort/ss", ss[0], 1);
    chk("abort/sclk", sclk[0], 0);
    chk("abort/mosi", mosi[0], 0);
    chk("abort/rsp_valid", rsp_valid[0], 0);
    repeat (2) tick();
    @(negedge clk);
    reset_b = 1'b1;
    tick();
    chk("abort/ready", req_ready[0], 1);
    repeat (20) tick();
    chk("abort/no_rsp", rsp_cnt[0] - r0, 0);
    do_op(0, 1'b0, 8'h22, 16'h0000, 16'h5A5A, 1'b0, "after_rst");

    do_op(1, 1'b0, 8'h3C, 16'h0000, 16'hAAAA, 1'b0, "d5_rdAAAA");
    do_op(1, 1'b1, 8'hC3, 16'h9876, 16'h9876, 1'b0, "d5_wr");
`ifdef NPU_SPI_CFG_READBACK_EN
    do_op(0, 1'b1, 8'h44, 16'h1234, 16'h1230, 1'b0, "rb_mismatch");
`endif

    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom);
      wd = 16'($urandom);
      sd = ($urandom_range(0, 1) == 1) ? wd : 16'($urandom);
      do_op(i % 2, wr, 8'($urandom), wd, sd, 1'b0, $sformatf("rnd%0d", i));
    end
    repeat (10) tick();

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("phase%0d", g), phase_err[g], 0);
      chk($sformatf("busy_ready%0d", g), busy_err[g], 0);
      chk($sformatf("pulse_width%0d", g), pulse_err[g], 0);
      mn = 1000;
      for (int i = 0; i < ngap[g]; i++) if (gapq[g][i] < mn) mn = gapq[g][i];
      chk($sformatf("min_gap%0d", g), 32'(mn >= IDLE_CYC), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
